store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 19 +
 rtl/store_buffer_align.sv | 35 +++
 rtl/store_buffer.sv | 108 ++++++++++
 tb/tb_store_buffer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared opcode ranges, byte-enable width and entry record for the store buffer
package store_buffer_pkg;

  localparam logic [4:0] OP_WORD_LO = 5'd3;
  localparam logic [4:0] OP_WORD_HI = 5'd5;
  localparam logic [4:0] OP_HALF_LO = 5'd6;
  localparam logic [4:0] OP_HALF_HI = 5'd8;
  localparam logic [4:0] OP_BYTE_LO = 5'd9;
  localparam logic [4:0] OP_BYTE_HI = 5'd11;

  localparam int BE_W = 4;

  typedef struct packed {
    logic [29:0]     word_addr;
    logic [31:0]     wdata;
    logic [BE_W-1:0] be;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_align.sv
// rtl/store_buffer_align.sv - combinational lane alignment of store data and byte enables
module store_align
  import store_buffer_pkg::*;
(
  input  logic [4:0]      opcode,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     data,
  output logic [31:0]     wdata,
  output logic [BE_W-1:0] be,
  output logic            illegal
);

  always_comb begin
    wdata   = '0;
    be      = '0;
    illegal = 1'b0;
    if (opcode >= OP_WORD_LO && opcode <= OP_WORD_HI) begin
      be    = 4'b1111;
      wdata = data;
    end else if (opcode >= OP_HALF_LO && opcode <= OP_HALF_HI) begin
      // an odd-aligned halfword straddles the middle lanes rather than faulting
      case (addr_lo)
        2'b00:   begin be = 4'b0011; wdata = {16'h0000, data[15:0]};       end
        2'b01:   begin be = 4'b0110; wdata = {8'h00, data[15:0], 8'h00};   end
        default: begin be = 4'b1100; wdata = {data[15:0], 16'h0000};       end
      endcase
    end else if (opcode >= OP_BYTE_LO && opcode <= OP_BYTE_HI) begin
      be    = 4'b0001 << addr_lo;
      wdata = {24'h000000, data[7:0]} << {addr_lo, 3'b000};
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO store buffer with lane alignment, in-order memory drain and load hazard check
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       halt,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 opcode,
  input  logic [31:0]                addr,
  input  logic [31:0]                data,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [BE_W-1:0]            mem_be,
  input  logic                       mem_ack,
  input  logic [31:0]                ld_check_addr,
  output logic                       ld_hazard,
  output logic                       illegal_op,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  sb_entry_t       entries [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count_next;
  logic [PW-1:0]   off;
  logic [31:0]     al_wdata;
  logic [BE_W-1:0] al_be;
  logic            al_illegal;
  logic            full;
  logic            accept;
  logic            push;
  logic            pop;
  logic            ld_unused;

  store_align u_align (
    .opcode  (opcode),
    .addr_lo (addr[1:0]),
    .data    (data),
    .wdata   (al_wdata),
    .be      (al_be),
    .illegal (al_illegal)
  );

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready && clk_en && !halt;
  assign push      = accept && !al_illegal;
  assign pop       = mem_req && mem_ack;
  assign ld_unused = ^ld_check_addr[1:0];

  assign mem_addr  = {entries[head].word_addr, 2'b00};
  assign mem_wdata = entries[head].wdata;
  assign mem_be    = entries[head].be;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  // entry i is live when its distance from head is below count
  always_comb begin
    ld_hazard = 1'b0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if (CW'(off) < count && entries[i].word_addr == ld_check_addr[31:2])
        ld_hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      entries[tail] <= '{word_addr: addr[31:2], wdata: al_wdata, be: al_be};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      mem_req    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      if (push)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
      count      <= count_next;
      mem_req    <= (count_next != '0);
      illegal_op <= accept && al_illegal;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        halt = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  opcode = 5'd0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] ld_check_addr = '0;
  logic        ld_hazard;
  logic        illegal_op;
  logic [2:0]  count;
  logic        empty;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_en        (clk_en),
    .halt          (halt),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .addr          (addr),
    .data          (data),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_ack       (mem_ack),
    .ld_check_addr (ld_check_addr),
    .ld_hazard     (ld_hazard),
    .illegal_op    (illegal_op),
    .count         (count),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d);
    opcode   = op;
    addr     = a;
    data     = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic store(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] ebe);
    send(op, a, d);
    exp_q.push_back('{a: ea, d: ed, be: ebe});
  endtask

  task automatic drain();
    int n = 0;
    mem_ack = 1'b1;
    while (mem_req && n < 20) begin
      tick();
      n++;
    end
    mem_ack = 1'b0;
    chk("drain_idle", {31'b0, mem_req}, 32'd0);
  endtask

  // monitor: every accepted drain beat must match the oldest expected store
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_drain: got addr 0x%0h expected no request", mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("drain_addr", mem_addr, e.a);
          chk("drain_wdata", mem_wdata, e.d);
          chk("drain_be", {28'b0, mem_be}, {28'b0, e.be});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_illegal", {31'b0, illegal_op}, 32'd0);
    chk("rst_hazard", {31'b0, ld_hazard}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // byte store into the top lane
    store(5'd9, 32'h1003, 32'hAB, 32'h1000, 32'hAB000000, 4'b1000);
    chk("byte_mem_req", {31'b0, mem_req}, 32'd1);
    chk("byte_mem_addr", mem_addr, 32'h1000);
    chk("byte_be", {28'b0, mem_be}, 32'b1000);
    chk("byte_wdata", mem_wdata, 32'hAB000000);
    drain();
    chk("byte_empty", {31'b0, empty}, 32'd1);

    // halfword/byte alignment, head held stable while not acked
    store(5'd6, 32'h2001, 32'hDEAD1234, 32'h2000, 32'h00123400, 4'b0110);
    store(5'd6, 32'h2002, 32'hDEAD1234, 32'h2000, 32'h12340000, 4'b1100);
    store(5'd7, 32'h2000, 32'hBEEF5678, 32'h2000, 32'h00005678, 4'b0011);
    store(5'd10, 32'h4002, 32'h123456CD, 32'h4000, 32'h00CD0000, 4'b0100);
    chk("align_count", {29'b0, count}, 32'd4);
    chk("align_head_be", {28'b0, mem_be}, 32'b0110);
    chk("align_head_wdata", mem_wdata, 32'h00123400);
    drain();

    // illegal opcode and gated accept
    send(5'd12, 32'h7000, 32'h1);
    chk("illegal_pulse", {31'b0, illegal_op}, 32'd1);
    chk("illegal_count", {29'b0, count}, 32'd0);
    tick();
    chk("illegal_clear", {31'b0, illegal_op}, 32'd0);
    clk_en = 1'b0;
    send(5'd3, 32'h7000, 32'h1);
    chk("clk_en_count", {29'b0, count}, 32'd0);
    clk_en = 1'b1;

    // load hazard
    store(5'd3, 32'h3000, 32'h11111111, 32'h3000, 32'h11111111, 4'b1111);
    ld_check_addr = 32'h3002;
    #1;
    chk("hazard_same_word", {31'b0, ld_hazard}, 32'd1);
    ld_check_addr = 32'h3004;
    #1;
    chk("hazard_next_word", {31'b0, ld_hazard}, 32'd0);
    opcode = 5'd3;
    addr = 32'h3008;
    data = 32'h22222222;
    ld_check_addr = 32'h3008;
    in_valid = 1'b1;
    #1;
    chk("hazard_excl_accept", {31'b0, ld_hazard}, 32'd0);
    tick();
    in_valid = 1'b0;
    exp_q.push_back('{a: 32'h3008, d: 32'h22222222, be: 4'b1111});
    chk("hazard_after_enq", {31'b0, ld_hazard}, 32'd1);
    drain();
    ld_check_addr = '0;

    // fill to full, then the fifth enters one cycle after the first ack
    opcode = 5'd3;
    for (int i = 0; i < 5; i++) begin
      addr = 32'h100 + 32'(4 * i);
      data = 32'hA000 + 32'(i);
      in_valid = 1'b1;
      #1;
      chk("b2b_ready", {31'b0, in_ready}, {31'b0, (i < 4)});
      if (i < 4) begin
        tick();
        exp_q.push_back('{a: 32'h100 + 32'(4 * i), d: 32'hA000 + 32'(i), be: 4'b1111});
      end
    end
    chk("full_count", {29'b0, count}, 32'd4);
    chk("full_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("full_hold_count", {29'b0, count}, 32'd4);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("first_pop_count", {29'b0, count}, 32'd3);
    chk("first_pop_ready", {31'b0, in_ready}, 32'd1);
    tick();
    exp_q.push_back('{a: 32'h110, d: 32'hA004, be: 4'b1111});
    in_valid = 1'b0;
    chk("fifth_accept_count", {29'b0, count}, 32'd4);

    // drain to two, then drain under halt with a pending request
    mem_ack = 1'b1;
    tick();
    tick();
    chk("pre_halt_count", {29'b0, count}, 32'd2);
    halt = 1'b1;
    addr = 32'h900;
    in_valid = 1'b1;
    tick();
    chk("halt_drain1", {29'b0, count}, 32'd1);
    tick();
    chk("halt_drain2", {29'b0, count}, 32'd0);
    chk("halt_mem_req", {31'b0, mem_req}, 32'd0);
    halt = 1'b0;
    in_valid = 1'b0;
    mem_ack = 1'b0;

    // reset mid-transfer discards everything immediately
    store(5'd3, 32'hA00, 32'h1, 32'hA00, 32'h1, 4'b1111);
    store(5'd3, 32'hA04, 32'h2, 32'hA04, 32'h2, 4'b1111);
    store(5'd3, 32'hA08, 32'h3, 32'hA08, 32'h3, 4'b1111);
    chk("pre_rst_count", {29'b0, count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("async_rst_count", {29'b0, count}, 32'd0);
    chk("async_rst_empty", {31'b0, empty}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_mem_req", {31'b0, mem_req}, 32'd0);

    // simultaneous push and pop keeps count
    store(5'd5, 32'h5003, 32'hCAFEBABE, 32'h5000, 32'hCAFEBABE, 4'b1111);
    opcode = 5'd11;
    addr = 32'h6001;
    data = 32'h77;
    in_valid = 1'b1;
    mem_ack = 1'b1;
    tick();
    in_valid = 1'b0;
    mem_ack = 1'b0;
    exp_q.push_back('{a: 32'h6000, d: 32'h00007700, be: 4'b0010});
    chk("pushpop_count", {29'b0, count}, 32'd1);
    chk("pushpop_head", mem_addr, 32'h6000);
    drain();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
